// File: rtl/trace_capture_buffer_if.sv
// Retire-port bundle and FWFT drain stream for the trace capture buffer.
// The recorder takes the slave side; the core/consumer side is the master.
interface trace_capture_buffer_if #(
    parameter int XLEN  = 32,
    parameter int LANES = 2,
    parameter int TS_W  = 16
);
    logic [LANES-1:0]      ret_valid;
    logic [LANES*XLEN-1:0] ret_pc;
    logic [LANES*32-1:0]   ret_inst;
    logic [LANES*5-1:0]    ret_rd_idx;
    logic [LANES*XLEN-1:0] ret_wb_data;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [XLEN-1:0]       rd_pc;
    logic [31:0]           rd_inst;
    logic [4:0]            rd_rd_idx;
    logic [XLEN-1:0]       rd_wb_data;
    logic [TS_W-1:0]       rd_tstamp;

    modport master (
        output ret_valid, ret_pc, ret_inst, ret_rd_idx, ret_wb_data,
        output rd_ready,
        input  rd_valid, rd_pc, rd_inst, rd_rd_idx, rd_wb_data, rd_tstamp
    );

    modport slave (
        input  ret_valid, ret_pc, ret_inst, ret_rd_idx, ret_wb_data,
        input  rd_ready,
        output rd_valid, rd_pc, rd_inst, rd_rd_idx, rd_wb_data, rd_tstamp
    );
endinterface

// File: rtl/trace_capture_buffer.sv
// Multi-lane retirement trace recorder: circular buffer with wrap, stop-when-full
// and PC-trigger capture modes, drained through a first-word-fall-through stream.
module trace_capture_buffer #(
    parameter int XLEN  = 32,
    parameter int LANES = 2,
    parameter int DEPTH = 64,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cfg_mode,
    input  logic [XLEN-1:0]          cfg_trig_pc,
    input  logic [$clog2(DEPTH):0]   cfg_post_trig,
    input  logic                     arm,
    input  logic                     stop,
    trace_capture_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              dropped,
    output logic [1:0]               state,
    output logic                     triggered
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0]   DEP1 = CW1'(DEPTH);
    localparam logic [CW-1:0] DEPC = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_q, post_d;
    logic [15:0]     dropped_q, dropped_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            triggered_q, triggered_d;

    logic [XLEN-1:0] pc_m  [DEPTH];
    logic [31:0]     ins_m [DEPTH];
    logic [4:0]      rd_m  [DEPTH];
    logic [XLEN-1:0] wb_m  [DEPTH];
    logic [TS_W-1:0] ts_m  [DEPTH];

    logic [LANES-1:0] wr_en;
    logic [AW-1:0]    wr_slot [LANES];

    logic            rd_valid_w;
    logic            pop;
    logic            cap;
    logic            mode_stop;
    logic            mode_trig;
    state_e          ph;
    logic [CW-1:0]   left;
    logic [CW-1:0]   nw;
    logic [2:0]      ndrop;
    logic [CW:0]     occ;
    logic [CW-1:0]   ovw;
    logic [16:0]     dsum;

    assign rd_valid_w = (count_q != '0);
    // Reserved mode 3 behaves exactly like STOP.
    assign mode_stop  = cfg_mode[0];
    assign mode_trig  = (cfg_mode == 2'd2);

    always_comb begin
        pop         = rd_valid_w & bus.rd_ready;
        ph          = state_q;
        left        = post_q;
        triggered_d = triggered_q;
        nw          = '0;
        ndrop       = '0;
        wr_en       = '0;
        occ         = '0;
        for (int i = 0; i < LANES; i++) wr_slot[i] = '0;
        cap = (state_q == S_RUN || state_q == S_POST) && !stop;

        // ph tracks the phase lane-by-lane so a mid-cycle trigger or window end
        // changes how the following lanes of the same cycle are treated.
        for (int i = 0; i < LANES; i++) begin
            occ = {1'b0, count_q} - CW1'(pop) + {1'b0, nw};
            if (bus.ret_valid[i]) begin
                if (cap && ph == S_RUN) begin
                    if (mode_stop && occ >= DEP1) begin
                        ndrop = ndrop + 3'd1;
                    end else begin
                        wr_en[i]   = 1'b1;
                        wr_slot[i] = tail_q + nw[AW-1:0];
                        nw         = nw + 1'b1;
                        if (mode_trig && bus.ret_pc[i*XLEN +: XLEN] == cfg_trig_pc) begin
                            triggered_d = 1'b1;
                            if (cfg_post_trig == '0) begin
                                ph = S_FROZEN;
                            end else begin
                                ph   = S_POST;
                                left = cfg_post_trig;
                            end
                        end
                    end
                end else if (cap && ph == S_POST) begin
                    wr_en[i]   = 1'b1;
                    wr_slot[i] = tail_q + nw[AW-1:0];
                    nw         = nw + 1'b1;
                    left       = left - 1'b1;
                    if (left == '0) ph = S_FROZEN;
                end else if (state_q == S_FROZEN && mode_stop) begin
                    ndrop = ndrop + 3'd1;
                end
            end
        end

        occ       = {1'b0, count_q} - CW1'(pop) + {1'b0, nw};
        ovw       = (occ > DEP1) ? CW'(occ - DEP1) : '0;
        count_d   = CW'(occ) - ovw;
        head_d    = head_q + AW'(pop) + ovw[AW-1:0];
        tail_d    = tail_q + nw[AW-1:0];
        dsum      = {1'b0, dropped_q} + 17'(ovw) + 17'(ndrop);
        dropped_d = dsum[16] ? 16'hFFFF : dsum[15:0];
        post_d    = left;
        ts_d      = ts_q + 1'b1;

        state_d = ph;
        if (ph == S_RUN && mode_stop && count_d == DEPC) state_d = S_FROZEN;
        if (stop) state_d = S_FROZEN;

        if (arm) begin
            wr_en       = '0;
            count_d     = '0;
            head_d      = '0;
            tail_d      = '0;
            dropped_d   = '0;
            triggered_d = 1'b0;
            ts_d        = '0;
            post_d      = '0;
            state_d     = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            post_q      <= '0;
            dropped_q   <= '0;
            ts_q        <= '0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            post_q      <= post_d;
            dropped_q   <= dropped_d;
            ts_q        <= ts_d;
            triggered_q <= triggered_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                pc_m[wr_slot[i]]  <= bus.ret_pc[i*XLEN +: XLEN];
                ins_m[wr_slot[i]] <= bus.ret_inst[i*32 +: 32];
                rd_m[wr_slot[i]]  <= bus.ret_rd_idx[i*5 +: 5];
                wb_m[wr_slot[i]]  <= bus.ret_wb_data[i*XLEN +: XLEN];
                ts_m[wr_slot[i]]  <= ts_q;
            end
        end
    end

    assign bus.rd_valid   = rd_valid_w;
    assign bus.rd_pc      = pc_m[head_q];
    assign bus.rd_inst    = ins_m[head_q];
    assign bus.rd_rd_idx  = rd_m[head_q];
    assign bus.rd_wb_data = wb_m[head_q];
    assign bus.rd_tstamp  = ts_m[head_q];

    assign count     = count_q;
    assign dropped   = dropped_q;
    assign state     = state_q;
    assign triggered = triggered_q;
endmodule
